// File: rtl/microcode_pkg.sv
// Shared definitions for the multi-cycle control decoder microcode store.
// Holds the field map, select encodings, region bases and the ROM image.
package microcode_pkg;

  localparam int unsigned UCODE_DEPTH = 256;
  localparam int unsigned UCODE_WIDTH = 40;

  // Region bases; the decoder adds the opcode to one of these per FSM state.
  localparam logic [7:0] DECODE_BASE = 8'd0;
  localparam logic [7:0] READ_BASE   = 8'd64;
  localparam logic [7:0] EXEC_BASE   = 8'd128;
  localparam logic [1:0] UNPOP_REGION = 2'b11;

  // Single-bit control strobes.
  localparam int unsigned MAR_LOAD_BIT = 39;
  localparam int unsigned IR_LOAD_BIT  = 38;
  localparam int unsigned MDR_LOAD_BIT = 37;
  localparam int unsigned REG_LOAD_BIT = 36;
  localparam int unsigned RAM_LOAD_BIT = 35;
  localparam int unsigned INCR_PC_BIT  = 34;
  localparam int unsigned BE_BIT       = 32;
  localparam int unsigned COND_CHK_BIT = 8;

  // Multi-bit field LSB positions.
  localparam int unsigned REGR0_LSB = 28;
  localparam int unsigned REGR1_LSB = 24;
  localparam int unsigned REGW_LSB  = 20;
  localparam int unsigned MDRS_LSB  = 18;
  localparam int unsigned IMM_LSB   = 15;
  localparam int unsigned OP0S_LSB  = 13;
  localparam int unsigned OP1S_LSB  = 11;
  localparam int unsigned COND_LSB  = 9;
  localparam int unsigned ALU_LSB   = 5;
  localparam int unsigned SKIP_LSB  = 3;

  // Register selects: codes 0-7 name a literal register.
  typedef enum logic [3:0] {
    SelArg0 = 4'd8,
    SelArg1 = 4'd9,
    SelTgt  = 4'd10,
    SelTgt2 = 4'd11
  } reg_sel_e;

  typedef enum logic [2:0] {
    Imm7  = 3'd0,
    Imm10 = 3'd1,
    Imm13 = 3'd2,
    ImmIr = 3'd3,
    Imm7u = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    SkipRead  = 2'd0,
    SkipExec  = 2'd1,
    SkipFetch = 2'd2
  } skip_e;

  // Fetch: MAR_LOAD, IR_LOAD, INCR_PC.
  localparam logic [UCODE_WIDTH-1:0] UCODE_FETCH = 40'hC4_0000_0000;
  localparam logic [UCODE_WIDTH-1:0] UCODE_IDLE  = 40'h0;

  localparam logic [UCODE_WIDTH-1:0] UCODE_INIT [UCODE_DEPTH] = '{
    2:       UCODE_FETCH,
    3:       UCODE_IDLE,
    default: 40'h0
  };

endpackage

// File: rtl/microcode_rom.sv
// 256 x 40-bit microcode store with a sticky flag for unpopulated-region fetches.
// Optional build macro UCODE_REGOUT_EN registers the read data (1-cycle latency).
module microcode_rom
  import microcode_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              illegal_hit
);

  logic              unpop_hit;
  logic [DATA_W-1:0] rom_word;
  logic              illegal_q;

  assign unpop_hit = (address[ADDR_W-1 -: 2] == UNPOP_REGION);

  // The unpopulated region is forced to zero regardless of the image contents.
  always_comb begin
    rom_word = DATA_W'(UCODE_INIT[address]);
    if (unpop_hit) begin
      rom_word = '0;
    end
  end

  // An unknown region compare evaluates false here, so X/Z never sets the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (unpop_hit) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_hit = illegal_q;

`ifdef UCODE_REGOUT_EN
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= rom_word;
    end
  end

  assign data = data_q;
`else
  assign data = rom_word;
`endif

endmodule

// File: tb/tb_microcode_rom.sv
// Directed self-checking bench for microcode_rom (honours UCODE_REGOUT_EN if defined).
module tb_microcode_rom;

  logic        clk;
  logic        reset;
  logic [7:0]  address;
  logic [39:0] data;
  logic        illegal_hit;

  int checks;
  int errors;

  localparam logic [39:0] FETCH_WORD = 40'hC400000000;

  microcode_rom dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .data        (data),
    .illegal_hit (illegal_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected image: only word 2 is populated.
  function automatic logic [39:0] model_word(input int a);
    return (a == 2) ? FETCH_WORD : 40'h0;
  endfunction

  // Present an address and wait until the read is visible, away from the clock edge.
  task automatic present(input logic [7:0] a);
    address = a;
`ifdef UCODE_REGOUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    address = 8'd255;

    // Clock edges while reset is low must not set the flag even on an illegal address.
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_illegal", 40'(illegal_hit), 40'h0);
    check_eq("reset_data", data, 40'h0);

    @(negedge clk);
    address = 8'd2;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_no_set", 40'(illegal_hit), 40'h0);

    present(8'd2);
    check_eq("word2", data, FETCH_WORD);
    check_eq("word2_illegal", 40'(illegal_hit), 40'h0);
    check_eq("f_mar_load", 40'(data[39]), 40'h1);
    check_eq("f_ir_load", 40'(data[38]), 40'h1);
    check_eq("f_incr_pc", 40'(data[34]), 40'h1);
    check_eq("f_skip", 40'(data[4:3]), 40'h0);
    check_eq("f_others", data & ~40'hC4_0000_0000, 40'h0);

    present(8'd3);
    check_eq("word3", data, 40'h0);

    for (int a = 0; a < 192; a++) begin
      present(8'(a));
      check_eq($sformatf("sweep_%0d", a), data, model_word(a));
    end
    check_eq("sweep_illegal", 40'(illegal_hit), 40'h0);

`ifdef UCODE_REGOUT_EN
    present(8'd3);
    @(negedge clk);
    address = 8'd2;
    #1;
    check_eq("regout_hold", data, 40'h0);
    @(posedge clk);
    #1;
    check_eq("regout_update", data, FETCH_WORD);
`endif

    // Illegal fetch sets the sticky flag on the next rising edge.
    @(negedge clk);
    address = 8'd200;
    @(posedge clk);
    #1;
    check_eq("addr200_data", data, 40'h0);
    check_eq("addr200_illegal", 40'(illegal_hit), 40'h1);

    address = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    check_eq("sticky", 40'(illegal_hit), 40'h1);
    check_eq("sticky_data", data, FETCH_WORD);

    // Asynchronous clear mid-cycle, well away from any edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_clear", 40'(illegal_hit), 40'h0);
`ifdef UCODE_REGOUT_EN
    check_eq("async_data_clear", data, 40'h0);
`endif
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("after_release", 40'(illegal_hit), 40'h0);

    for (int a = 192; a < 256; a++) begin
      present(8'(a));
      check_eq($sformatf("unpop_%0d", a), data, 40'h0);
    end
    @(posedge clk);
    #1;
    check_eq("unpop_illegal", 40'(illegal_hit), 40'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
